// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters in the top are enabled by HAZ_PERF_CNT_EN.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    IMEM_WAIT  = 2'd2,
    BR_FLUSH   = 2'd3
  } haz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between EX load and ID reader.
// Register 0 is hardwired, so a load to it never creates a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt && (ex_rt == id_rt);

  assign hazard = ex_mem_read
               && (ex_rt != '0)
               && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard FSM: branch flush, imem wait/timeout, load-use stall.
// Define HAZ_PERF_CNT_EN to add stall_cnt/flush_cnt perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int IMEM_TMO = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  imem_err,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
`endif
  output logic [1:0]            state_o
);

  haz_state_t state_q, state_d;
  logic [2:0] stl_q, stl_d;
  logic [7:0] wt_q, wt_d;
  logic       err_q, err_d;
  logic       hazard;

  localparam logic [2:0] STL_INIT = 3'(LOAD_LAT - 1);
  localparam logic [7:0] WT_MAX   = 8'(IMEM_TMO);

  load_use_detect u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  always_comb begin
    state_d     = RUN;
    stl_d       = '0;
    wt_d        = imem_ready ? 8'd0 : wt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = BR_FLUSH;
    end else if (!imem_ready) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = hazard;
      wt_d        = (wt_q >= WT_MAX) ? wt_q : wt_q + 8'd1;
      state_d     = IMEM_WAIT;
    end else if (state_q == LOAD_STALL) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      stl_d       = stl_q - 3'd1;
      state_d     = (stl_q <= 3'd1) ? RUN : LOAD_STALL;
    end else if (hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_LAT > 1) begin
        stl_d   = STL_INIT;
        state_d = LOAD_STALL;
      end
    end
    err_d = err_q | (wt_d >= WT_MAX);
    // Reset holds the pipe frozen with NOPs entering both latches
    if (!rst_n) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      stl_q   <= '0;
      wt_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stl_q   <= stl_d;
      wt_q    <= wt_d;
      err_q   <= err_d;
    end
  end

  assign imem_err = err_q;
  assign state_o  = state_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we)
        stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Build with HAZ_PERF_CNT_EN to also check the perf counters.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read;
  logic       branch_taken, imem_ready;
  logic       pc_we, ifid_we, ifid_flush;
  logic       idex_bubble, imem_err;
  logic [1:0] state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .LOAD_LAT (2),
    .IMEM_TMO (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .pc_we        (pc_we),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .imem_err     (imem_err),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .state_o      (state_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    ex_rt        = 5'd0;
    id_uses_rt   = 1'b0;
    ex_mem_read  = 1'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b1;
  endtask

  task automatic load_use(input logic [4:0] r);
    ex_mem_read = 1'b1;
    ex_rt       = r;
    id_rs       = r;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    check("rst_pc_we", pc_we, 0);
    check("rst_ifid_we", ifid_we, 0);
    check("rst_flush", ifid_flush, 1);
    check("rst_bubble", idex_bubble, 1);
    check("rst_state", state_o, 0);
    check("rst_err", imem_err, 0);
    rst_n = 1'b1;
    #1;
    check("run_pc_we", pc_we, 1);
    check("run_ifid_we", ifid_we, 1);
    check("run_flush", ifid_flush, 0);
    check("run_bubble", idex_bubble, 0);
    tick();

    // Load-use on rs, two stall cycles
    load_use(5'd8);
    #1;
    check("lu1_pc_we", pc_we, 0);
    check("lu1_ifid_we", ifid_we, 0);
    check("lu1_bubble", idex_bubble, 1);
    tick();
    check("lu2_state", state_o, 1);
    check("lu2_pc_we", pc_we, 0);
    check("lu2_bubble", idex_bubble, 1);
    tick();
    idle();
    #1;
    check("lu3_state", state_o, 0);
    check("lu3_pc_we", pc_we, 1);
    check("lu3_bubble", idex_bubble, 0);
`ifdef HAZ_PERF_CNT_EN
    check("perf_stall", stall_cnt, 2);
    check("perf_flush", flush_cnt, 0);
`endif
    tick();

    // Load to r0 never stalls
    ex_mem_read = 1'b1;
    #1;
    check("r0_pc_we", pc_we, 1);
    check("r0_bubble", idex_bubble, 0);

    // rt match only counts when rt is read
    ex_rt = 5'd5;
    id_rs = 5'd1;
    id_rt = 5'd5;
    #1;
    check("rt_unused", pc_we, 1);
    id_uses_rt = 1'b1;
    #1;
    check("rt_used", pc_we, 0);
    tick();
    idle();
    tick();
    check("rt_back_run", state_o, 0);

    // Branch beats a simultaneous load-use
    load_use(5'd3);
    branch_taken = 1'b1;
    #1;
    check("br_flush", ifid_flush, 1);
    check("br_bubble", idex_bubble, 1);
    check("br_pc_we", pc_we, 1);
    tick();
    idle();
    #1;
    check("br_state", state_o, 3);
    check("br_fl_pc_we", pc_we, 1);
    check("br_fl_flush", ifid_flush, 0);
    tick();
    check("br_done", state_o, 0);

    // imem miss during LOAD_STALL drops the stall
    load_use(5'd9);
    tick();
    check("ls_state", state_o, 1);
    idle();
    imem_ready = 1'b0;
    #1;
    check("iw_pc_we", pc_we, 0);
    check("iw_flush", ifid_flush, 1);
    check("iw_bubble", idex_bubble, 0);
    tick();
    check("iw_state", state_o, 2);
    imem_ready = 1'b1;
    #1;
    check("iw_exit_pc", pc_we, 1);
    check("iw_exit_fl", ifid_flush, 0);
    tick();
    check("iw_run", state_o, 0);
    check("iw_no_err", imem_err, 0);

    // Timeout after 15 consecutive wait cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("tmo_14", imem_err, 0);
    tick();
    check("tmo_15", imem_err, 1);
    imem_ready = 1'b1;
    tick();
    check("tmo_sticky", imem_err, 1);
    check("tmo_run", state_o, 0);

    // Reset in the middle of a load stall
    load_use(5'd4);
    tick();
    check("rs_stall", state_o, 1);
    rst_n = 1'b0;
    #1;
    check("rs_flush", ifid_flush, 1);
    check("rs_pc_we", pc_we, 0);
    check("rs_state", state_o, 0);
    check("rs_err", imem_err, 0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    check("rs_rel_st", state_o, 0);
    check("rs_rel_pc", pc_we, 1);
    tick();
    check("rs_run", state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: LOAD_LAT, default 1, stall cycles for load-use (1..7); IMEM_TMO, default 15, max consecutive imem wait cycles before error (1..255).
REQ-002 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port id_rs  input  5  rs field of the instruction held in the IF/ID latch.
REQ-005 Port id_rt  input  5  rt field of the instruction held in the IF/ID latch.
REQ-006 Port id_uses_rt  input  1  ID instruction reads rt.
REQ-007 Port ex_mem_read  input  1  instruction in EX is a load.
REQ-008 Port ex_rt  input  5  destination register of the EX load.
REQ-009 Port branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-010 Port imem_ready  input  1  instruction memory returns valid instr_in this cycle.
REQ-011 Port pc_we  output  1  PC register write enable.
REQ-012 Port ifid_we  output  1  IF/ID latch load enable (0 = hold).
REQ-013 Port ifid_flush  output  1  IF/ID latch loads NOP (instr 0); overrides ifid_we.
REQ-014 Port idex_bubble  output  1  ID/EX latch loads NOP.
REQ-015 Port imem_err  output  1  sticky instruction-memory timeout flag.
REQ-016 Port state_o  output  2  current FSM state encoding.

Function
REQ-017 FSM states SHALL be RUN=0, LOAD_STALL=1, IMEM_WAIT=2, BR_FLUSH=3; outputs combinational from state and inputs.
REQ-018 Load-use hazard SHALL be: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
REQ-019 Priority each cycle SHALL be branch_taken > imem_ready==0 > load-use hazard > normal advance.
REQ-020 RUN, no event: pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
REQ-021 branch_taken in any state: pc_we=1, ifid_flush=1, idex_bubble=1, stall counter cleared, next state BR_FLUSH.
REQ-022 BR_FLUSH lasts exactly one cycle with RUN outputs, then RUN; branch_taken again re-enters BR_FLUSH.
REQ-023 Load-use in RUN: pc_we=0, ifid_we=0, idex_bubble=1; if LOAD_LAT>1 go LOAD_STALL with counter=LOAD_LAT-1, else stay RUN.
REQ-024 LOAD_STALL: same outputs as REQ-023, counter decrements each cycle; at counter==1 next state RUN.
REQ-025 imem_ready==0 (RUN, BR_FLUSH, or LOAD_STALL): pc_we=0, ifid_flush=1, idex_bubble per load-use result, wait counter increments, next IMEM_WAIT; a pending LOAD_STALL count is discarded.
REQ-026 IMEM_WAIT exits to RUN on the first cycle imem_ready==1, RUN outputs that cycle.
REQ-027 Wait counter reaching IMEM_TMO SHALL set imem_err; counter saturates; imem_err clears only on reset.
REQ-028 Wait counter SHALL clear on any cycle imem_ready==1.

Reset
REQ-029 While rst_n==0: state RUN, counters 0, imem_err 0, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1.
REQ-030 Reset asserted mid-stall SHALL abandon the stall; first post-reset cycle behaves per RUN.

Configuration
REQ-031 Macro HAZ_PERF_CNT_EN defined: add outputs stall_cnt (32) and flush_cnt (32), counting cycles with pc_we==0 and cycles with ifid_flush==1, wrapping at 2^32, reset 0.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Package pipe_ctrl_pkg SHALL hold the state enum, REG_ADDR_W=5 and NOP_INSTR=32'h0.
REQ-034 Sub-module load_use_detect SHALL implement REQ-018 combinationally.

Verification
REQ-035 Load ex_rt=8, id_rs=8, LOAD_LAT=2 -> pc_we=0/idex_bubble=1 for 2 cycles, then RUN outputs.
REQ-036 ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, pc_we=1.
REQ-037 branch_taken with simultaneous load-use -> ifid_flush=1, idex_bubble=1, pc_we=1; next cycle state_o=3, then 0.
REQ-038 imem_ready=0 for 15 cycles, IMEM_TMO=15 -> imem_err=1 and stays 1 after imem_ready=1.
REQ-039 rst_n low during LOAD_STALL -> immediate ifid_flush=1, pc_we=0; after release state_o=0.
REQ-040 HAZ_PERF_CNT_EN set, REQ-035 run -> stall_cnt=2, flush_cnt=0.
